voice_mix_sequencer: RTL and testbench

- Time-multiplexed mix controller. Once per sample period it steps through all synth voices, reads each voice's 8-bit sample over a select/data port, and sums them.
- It also counts active voices and normalizes the sum into a 12-bit averaged output sample, handed to the audio output stage with a one-cycle valid strobe.
- Sits between the voice bank (oscillators) and the PWM/DAC output stage.
- Replaces the flat 13-input combinational mix with a sequenced, width-safe datapath.

---
 rtl/synth_pkg.sv | 25 ++
 rtl/mix_divider.sv | 61 ++++++
 rtl/voice_mix_sequencer.sv | 112 +++++++++++
 tb/tb_voice_mix_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants, state encoding and helpers for the voice mixing path.
// Imported by the mix sequencer and its divider.
package synth_pkg;

    localparam int NUM_VOICES  = 13;
    localparam int VOICE_W     = 8;
    localparam int OUT_W       = 12;
    localparam int VOICE_IDX_W = 4;
    localparam int ACC_W       = 12;
    localparam int CNT_W       = 4;
    localparam int DIV_W       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } mix_state_t;

    // Clamp a quotient to the output range; any bit above OUT_W means overflow.
    function automatic logic [OUT_W-1:0] sat_out(input logic [DIV_W-1:0] v);
        return (|v[DIV_W-1:OUT_W]) ? {OUT_W{1'b1}} : v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/mix_divider.sv
// Restoring unsigned divider: 16-bit dividend by 4-bit divisor, one quotient bit
// per cycle. The start cycle performs the first step, so done pulses 16 edges after start.
module mix_divider
    import synth_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [CNT_W-1:0] rem;
    logic [DIV_W-1:0] shreg;
    logic [3:0]       left;

    logic [CNT_W-1:0] src_rem;
    logic [DIV_W-1:0] src_sh;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;
    logic             fits;
    logic [CNT_W-1:0] next_rem;
    logic [DIV_W-1:0] next_sh;

    // Remainder always stays below the divisor, so it fits CNT_W bits between steps.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_sh   = start ? dividend : shreg;
        trial    = {src_rem, src_sh[DIV_W-1]};
        fits     = (trial >= {1'b0, divisor});
        diff     = trial - {1'b0, divisor};
        next_rem = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        next_sh  = {src_sh[DIV_W-2:0], fits};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rem   <= '0;
            shreg <= '0;
            left  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= next_rem;
                shreg <= next_sh;
                left  <= 4'd15;
            end else if (left != 4'd0) begin
                rem   <= next_rem;
                shreg <= next_sh;
                left  <= left - 4'd1;
                done  <= (left == 4'd1);
            end
        end
    end

    assign quotient = shreg;

endmodule

// File: rtl/voice_mix_sequencer.sv
// Sequenced voice mixer: scans one voice per cycle, then averages the enabled
// non-silent voices as (sum << 4) / count into a 12-bit sample with a valid pulse.
module voice_mix_sequencer
    import synth_pkg::*;
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   sample_tick,
    input  logic [NUM_VOICES-1:0]  voice_en,
    output logic [VOICE_IDX_W-1:0] voice_sel,
    input  logic [VOICE_W-1:0]     voice_sample,
    output logic [OUT_W-1:0]       mixed_sample,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output mix_state_t             state
);

    logic [15:0]      en_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] q;

    logic             take;
    logic             last_voice;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             div_start;
    logic             div_done;
    logic [DIV_W-1:0] div_quotient;

    // The divider is launched from the last scan cycle with the sums that include
    // that final voice, so DIVIDE spans exactly the 16 division steps.
    always_comb begin
        take       = (state == SCAN) && en_q[voice_sel] && (voice_sample != '0);
        last_voice = (voice_sel == VOICE_IDX_W'(NUM_VOICES - 1));
        acc_next   = acc + (take ? ACC_W'(voice_sample) : '0);
        cnt_next   = cnt + CNT_W'(take);
        div_start  = (state == SCAN) && last_voice && (cnt_next != '0);
    end

    mix_divider u_div (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (div_start),
        .dividend ({acc_next, 4'b0000}),
        .divisor  (cnt_next),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            en_q         <= '0;
            acc          <= '0;
            cnt          <= '0;
            q            <= '0;
            voice_sel    <= '0;
            mixed_sample <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && (state != IDLE))
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        en_q      <= 16'(voice_en);
                        acc       <= '0;
                        cnt       <= '0;
                        voice_sel <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                    if (last_voice) begin
                        voice_sel <= '0;
                        state     <= DIVIDE;
                    end else begin
                        voice_sel <= voice_sel + 1'b1;
                    end
                end
                DIVIDE: begin
                    if (cnt == '0) begin
                        q     <= '0;
                        state <= DONE;
                    end else if (div_done) begin
                        q     <= div_quotient;
                        state <= DONE;
                    end
                end
                DONE: begin
                    mixed_sample <= sat_out(q);
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Bench for voice_mix_sequencer: directed and random mixes against an averaging model,
// plus latency, reset-abort and overrun behaviour.
module tb_voice_mix_sequencer;
    import synth_pkg::*;

    logic                   clk = 1'b0;
    logic                   n_rst = 1'b0;
    logic                   sample_tick = 1'b0;
    logic [NUM_VOICES-1:0]  voice_en = '0;
    logic [VOICE_IDX_W-1:0] voice_sel;
    logic [VOICE_W-1:0]     voice_sample;
    logic [OUT_W-1:0]       mixed_sample;
    logic                   sample_valid;
    logic                   busy;
    logic                   overrun;
    logic                   overrun_clr = 1'b0;
    mix_state_t             state;

    logic [VOICE_W-1:0] voice_mem [16];
    int n_checks = 0;
    int n_fail   = 0;

    voice_mix_sequencer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sample_tick  (sample_tick),
        .voice_en     (voice_en),
        .voice_sel    (voice_sel),
        .voice_sample (voice_sample),
        .mixed_sample (mixed_sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .state        (state)
    );

    // Voice bank answers combinationally for the selected voice.
    assign voice_sample = voice_mem[voice_sel];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Average of enabled, non-zero voices scaled by 16, clamped to 12 bits.
    function automatic int ref_mix(input logic [NUM_VOICES-1:0] en);
        int sum = 0;
        int n = 0;
        int r;
        for (int i = 0; i < NUM_VOICES; i++)
            if (en[i] && voice_mem[i] != 0) begin
                sum += voice_mem[i];
                n++;
            end
        if (n == 0) return 0;
        r = (sum * 16) / n;
        return (r > 4095) ? 4095 : r;
    endfunction

    function automatic int ref_lat(input logic [NUM_VOICES-1:0] en);
        for (int i = 0; i < NUM_VOICES; i++)
            if (en[i] && voice_mem[i] != 0) return 1 + NUM_VOICES + 16 + 1;
        return 1 + NUM_VOICES + 1 + 1;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++)
            voice_mem[i] = (i >= NUM_VOICES || $urandom_range(0, 3) == 0)
                           ? 8'd0 : 8'($urandom_range(0, 255));
    endtask

    // Tick is sampled on the first posedge; the scrambled mask afterwards must be ignored.
    task automatic start_scan(input logic [NUM_VOICES-1:0] en);
        @(negedge clk);
        voice_en    = en;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        voice_en    = NUM_VOICES'($urandom);
    endtask

    // Latency counts the tick-sampling edge as cycle 1; 0 means no valid seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic run_mix(input string tag, input logic [NUM_VOICES-1:0] en);
        int lat;
        int exp_val;
        int exp_lat;
        exp_val = ref_mix(en);
        exp_lat = ref_lat(en);
        start_scan(en);
        check({tag, "_busy"}, busy, 1);
        wait_valid(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_value"}, mixed_sample, exp_val);
        @(posedge clk);
        #1;
        check({tag, "_valid_width"}, sample_valid, 0);
        check({tag, "_hold"}, mixed_sample, exp_val);
    endtask

    initial begin
        int lat;
        int pulses;
        int exp_val;
        for (int i = 0; i < 16; i++) voice_mem[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", state, IDLE);
        check("reset_sel", voice_sel, 0);
        check("reset_mix", mixed_sample, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        @(negedge clk);
        n_rst = 1'b1;

        fill_random();
        voice_mem[3] = 8'd255;
        run_mix("single_v3", 13'b0_0000_0000_1000);
        check("single_v3_abs", mixed_sample, 4080);

        fill_random();
        voice_mem[0] = 8'd100; voice_mem[1] = 8'd50; voice_mem[2] = 8'd30;
        run_mix("average3", 13'b0_0000_0000_0111);
        check("average3_abs", mixed_sample, 960);

        for (int i = 0; i < NUM_VOICES; i++) voice_mem[i] = 8'd200;
        run_mix("masked_all", '0);

        for (int i = 0; i < NUM_VOICES; i++) voice_mem[i] = 8'd0;
        run_mix("silent_all", '1);

        fill_random();
        voice_mem[0] = 8'd120; voice_mem[1] = 8'd0;
        run_mix("zero_not_counted", 13'b0_0000_0000_0011);
        check("zero_not_counted_abs", mixed_sample, 1920);

        for (int i = 0; i < NUM_VOICES; i++) voice_mem[i] = 8'd255;
        run_mix("full_load", '1);
        check("full_load_abs", mixed_sample, 4080);

        for (int t = 0; t < 12; t++) begin
            fill_random();
            run_mix($sformatf("rand%0d", t), NUM_VOICES'($urandom));
        end

        // Reset in the middle of a scan aborts with no output.
        start_scan('1);
        repeat (4) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("midreset_mix", mixed_sample, 0);
        check("midreset_busy", busy, 0);
        check("midreset_sel", voice_sel, 0);
        check("midreset_valid", sample_valid, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (sample_valid) pulses++;
        end
        check("midreset_no_output", pulses, 0);
        fill_random();
        voice_mem[5] = 8'd77;
        run_mix("after_reset", 13'b0_0000_0010_0001);

        // Overrun: extra ticks while busy are ignored and flag a sticky error.
        fill_random();
        voice_mem[4] = 8'd64; voice_mem[7] = 8'd192;
        exp_val = ref_mix(13'b0_0000_1001_0000);
        start_scan(13'b0_0000_1001_0000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        check("overrun_set", overrun, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("overrun_set_wins", overrun, 1);
        wait_valid(lat);
        check("overrun_first_valid", (lat != 0), 1);
        check("overrun_first_value", mixed_sample, exp_val);
        check("overrun_sticky", overrun, 1);
        @(posedge clk);
        #1;
        check("overrun_no_restart", busy, 0);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
